// File: rtl/key_pkg.sv
// key_pkg: shared state encoding and default timing constants for the key debouncer.
package key_pkg;
    typedef enum logic [1:0] {IDLE, PRESS_FILTER, PRESSED, RELEASE_FILTER} key_state_t;
    localparam int DEF_DEBOUNCE_CYCLES = 1000000;
    localparam int DEF_LONG_CYCLES     = 50000000;
endpackage

// File: rtl/key_sync.sv
// key_sync: STAGES-deep flop chain bringing an asynchronous input into the clk domain.
module key_sync #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);
    logic [STAGES-1:0] ff;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) ff <= {STAGES{RST_VAL}};
        else        ff <= {ff[STAGES-2:0], d};
    assign q = ff[STAGES-1];
endmodule

// File: rtl/key_debounce.sv
// key_debounce: synchronizes and debounces a push-button into a level plus press, release and long-press pulses.
module key_debounce import key_pkg::*; #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int LONG_CYCLES     = DEF_LONG_CYCLES,
    parameter bit KEY_ACTIVE_LOW  = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key,
    output logic key_level,
    output logic key_press,
    output logic key_release,
    output logic key_long
);
    localparam int DW = $clog2(DEBOUNCE_CYCLES);
    localparam int HW = $clog2(LONG_CYCLES);
    localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] H_LAST = HW'(LONG_CYCLES - 1);

    key_state_t    state;
    logic [DW-1:0] dcnt;
    logic [HW-1:0] hcnt;
    logic          long_done;
    logic          key_s;
    logic          ks;

    key_sync #(.STAGES(SYNC_STAGES), .RST_VAL(KEY_ACTIVE_LOW)) u_sync (
        .clk(clk), .rst_n(rst_n), .d(key), .q(key_s)
    );

    assign ks = key_s ^ KEY_ACTIVE_LOW;

    // long_done keeps a saturated hcnt from re-firing key_long across release bounces
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            dcnt        <= '0;
            hcnt        <= '0;
            long_done   <= 1'b0;
            key_level   <= 1'b0;
            key_press   <= 1'b0;
            key_release <= 1'b0;
            key_long    <= 1'b0;
        end else begin
            key_press   <= 1'b0;
            key_release <= 1'b0;
            key_long    <= 1'b0;
            case (state)
                IDLE:
                    if (ks) begin
                        state <= PRESS_FILTER;
                        dcnt  <= '0;
                    end
                PRESS_FILTER:
                    if (!ks) state <= IDLE;
                    else if (dcnt == D_LAST) begin
                        state     <= PRESSED;
                        hcnt      <= '0;
                        long_done <= 1'b0;
                        key_press <= 1'b1;
                        key_level <= 1'b1;
                    end else dcnt <= dcnt + 1'b1;
                PRESSED:
                    if (!ks) begin
                        state <= RELEASE_FILTER;
                        dcnt  <= '0;
                    end else if (hcnt == H_LAST) begin
                        key_long  <= ~long_done;
                        long_done <= 1'b1;
                    end else hcnt <= hcnt + 1'b1;
                RELEASE_FILTER:
                    if (ks) state <= PRESSED;
                    else if (dcnt == D_LAST) begin
                        state       <= IDLE;
                        key_release <= 1'b1;
                        key_level   <= 1'b0;
                    end else dcnt <= dcnt + 1'b1;
                default: begin
                    state     <= IDLE;
                    key_level <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_key_debounce.sv
// tb_key_debounce: directed checks of an active-low and an active-high key_debounce driven with mirrored keys.
module tb_key_debounce;
    import key_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic key = 1'b1;
    logic key_p = 1'b0;
    logic key_level, key_press, key_release, key_long;
    logic p_level, p_press, p_release, p_long;
    logic [3:0] o, op;
    int passed = 0;
    int total = 0;

    always #5 clk = ~clk;

    key_debounce #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .LONG_CYCLES(20), .KEY_ACTIVE_LOW(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .key(key),
        .key_level(key_level), .key_press(key_press), .key_release(key_release), .key_long(key_long)
    );

    key_debounce #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .LONG_CYCLES(20), .KEY_ACTIVE_LOW(1'b0)) dut_p (
        .clk(clk), .rst_n(rst_n), .key(key_p),
        .key_level(p_level), .key_press(p_press), .key_release(p_release), .key_long(p_long)
    );

    assign o  = {key_level, key_press, key_release, key_long};
    assign op = {p_level, p_press, p_release, p_long};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        else passed++;
    endtask

    // n edges with pressed = ~k, checking {level,press,release,long} of both instances after each edge
    task automatic seq(input string tag, input logic k, input int n, input logic [3:0] exp);
        for (int i = 0; i < n; i++) begin
            key   = k;
            key_p = ~k;
            @(posedge clk);
            #1;
            check(tag, 32'(o), 32'(exp));
            check({tag, "_p"}, 32'(op), 32'(exp));
        end
    endtask

    initial begin
        #1 rst_n = 1'b0;
        #2;
        check("rst_out", 32'(o), 32'h0);
        check("rst_out_p", 32'(op), 32'h0);
        check("rst_state", 32'(dut.state), 32'(IDLE));
        @(posedge clk);
        #1 rst_n = 1'b1;

        seq("press_wait", 1'b0, 6, 4'b0000);
        seq("press_pulse", 1'b0, 1, 4'b1100);
        seq("press_hold", 1'b0, 1, 4'b1000);

        seq("rel_bounce_hi", 1'b1, 2, 4'b1000);
        seq("rel_bounce_lo", 1'b0, 2, 4'b1000);
        seq("rel_wait", 1'b1, 6, 4'b1000);
        seq("rel_pulse", 1'b1, 1, 4'b0010);
        seq("rel_idle", 1'b1, 3, 4'b0000);

        seq("bounce_a", 1'b0, 3, 4'b0000);
        seq("bounce_b", 1'b1, 2, 4'b0000);
        seq("bounce_c", 1'b0, 3, 4'b0000);
        seq("bounce_d", 1'b1, 6, 4'b0000);
        check("bounce_idle", 32'(dut.state), 32'(IDLE));
        check("bounce_idle_p", 32'(dut_p.state), 32'(IDLE));

        seq("long_wait", 1'b0, 6, 4'b0000);
        seq("long_press", 1'b0, 1, 4'b1100);
        seq("long_hold", 1'b0, 19, 4'b1000);
        seq("long_pulse", 1'b0, 1, 4'b1001);
        seq("long_norepeat", 1'b0, 13, 4'b1000);
        seq("long_rel_wait", 1'b1, 6, 4'b1000);
        seq("long_rel", 1'b1, 1, 4'b0010);
        seq("long_idle", 1'b1, 2, 4'b0000);

        seq("rstm_filter", 1'b0, 5, 4'b0000);
        check("rstm_dcnt", 32'(dut.dcnt), 32'd2);
        check("rstm_state", 32'(dut.state), 32'(PRESS_FILTER));
        rst_n = 1'b0;
        #1;
        check("rstm_out", 32'(o), 32'h0);
        check("rstm_idle", 32'(dut.state), 32'(IDLE));
        check("rstm_dcnt0", 32'(dut.dcnt), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        seq("rstm_wait", 1'b0, 6, 4'b0000);
        seq("rstm_press", 1'b0, 1, 4'b1100);

        rst_n = 1'b0;
        #1;
        check("rstp_out", 32'(o), 32'h0);
        check("rstp_out_p", 32'(op), 32'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        seq("rstp_wait", 1'b0, 6, 4'b0000);
        seq("rstp_press", 1'b0, 1, 4'b1100);
        seq("rstp_hold", 1'b0, 1, 4'b1000);
        seq("rstp_rel_wait", 1'b1, 6, 4'b1000);
        seq("rstp_rel", 1'b1, 1, 4'b0010);
        seq("rstp_idle", 1'b1, 2, 4'b0000);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
